prog_loader: RTL and testbench

- Parametrised program loader in front of the processor's instruction memory port (a/d/we/exec).
- Accepts a valid/ready word stream and writes each word to consecutive addresses from a base address.
- Waits a programmable settle interval, then raises exec to start the processor.
- Replaces the manual per-address write sequencing previously driven from benches, and adds overflow detection and restart.

---
 rtl/prog_loader.sv | 180 ++++++++++++++++++
 tb/tb_prog_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader: streams words into instruction memory, then releases exec.    |
// | Optional feature macro: PROG_LOADER_CSUM_EN (trailing checksum word check) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module prog_loader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int DEPTH      = 512,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] d,
  output logic              we,
  output logic              exec,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
`ifdef PROG_LOADER_CSUM_EN
  ,
  output logic              csum_bad
`endif
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LOAD   = 3'd1;
  localparam logic [2:0] c_SETTLE = 3'd2;
  localparam logic [2:0] c_RUN    = 3'd3;
  localparam logic [2:0] c_ERR    = 3'd4;
`ifdef PROG_LOADER_CSUM_EN
  localparam logic [2:0] c_CSUM   = 3'd5;
`endif

  localparam int              c_SW    = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [c_SW-1:0] c_SETTLE_CNT = c_SW'(SETTLE_CYC);
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic [c_SW-1:0]   r_settle;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic              r_we;
  logic              r_exec;
  logic              r_ready;
  logic              r_busy;
  logic              r_err;
`ifdef PROG_LOADER_CSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              r_csum_bad;
`endif

  logic              w_xfer;
  logic [ADDR_W:0]   w_cnt_inc;

  assign w_xfer    = in_valid & r_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= c_IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_settle <= '0;
      r_a      <= '0;
      r_d      <= '0;
      r_we     <= 1'b0;
      r_exec   <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      r_sum      <= '0;
      r_csum_bad <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        c_IDLE, c_RUN, c_ERR: begin
          if (load_start) begin
            r_state <= c_LOAD;
            r_ptr   <= base_addr;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_exec  <= 1'b0;
            r_ready <= (c_DEPTH != '0);
            r_busy  <= 1'b1;
`ifdef PROG_LOADER_CSUM_EN
            r_sum      <= '0;
            r_csum_bad <= 1'b0;
`endif
          end
        end
        c_LOAD: begin
          if (w_xfer) begin
            r_a   <= r_ptr;
            r_d   <= in_data;
            r_we  <= 1'b1;
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= w_cnt_inc;
`ifdef PROG_LOADER_CSUM_EN
            r_sum <= r_sum + in_data;
            if (in_last) begin
              // ready stays high: the checksum word follows immediately
              r_state <= c_CSUM;
              r_ready <= 1'b1;
            end else begin
              r_ready <= (w_cnt_inc < c_DEPTH);
            end
`else
            if (in_last) begin
              r_state  <= c_SETTLE;
              r_ready  <= 1'b0;
              r_settle <= '0;
            end else begin
              r_ready <= (w_cnt_inc < c_DEPTH);
            end
`endif
          end else if (in_valid && (r_cnt == c_DEPTH)) begin
            r_state <= c_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
          end
        end
        c_SETTLE: begin
          // r_settle==N on the edge closing the N-th idle cycle after the last write
          if (r_settle == c_SETTLE_CNT) begin
            r_state <= c_RUN;
            r_exec  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
`ifdef PROG_LOADER_CSUM_EN
        c_CSUM: begin
          if (w_xfer) begin
            r_ready <= 1'b0;
            if (in_data == r_sum) begin
              r_state  <= c_SETTLE;
              r_settle <= '0;
            end else begin
              r_state    <= c_ERR;
              r_err      <= 1'b1;
              r_csum_bad <= 1'b1;
              r_busy     <= 1'b0;
            end
          end
        end
`endif
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign in_ready = r_ready;
  assign a        = r_a;
  assign d        = r_d;
  assign we       = r_we;
  assign exec     = r_exec;
  assign busy     = r_busy;
  assign err      = r_err;
  assign word_cnt = r_cnt;
`ifdef PROG_LOADER_CSUM_EN
  assign csum_bad = r_csum_bad;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// Directed bench for prog_loader: basic load, wrap, reload, overflow, reset, checksum.
module tb_prog_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int TB_DEPTH = 8;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst, load_start, in_valid, in_last;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] in_data;
  logic in_ready, we, exec, busy, err;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic [ADDR_W:0] word_cnt;
`ifdef PROG_LOADER_CSUM_EN
  logic csum_bad;
`endif

  int total = 0;
  int bad = 0;

  prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(TB_DEPTH), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .a(a), .d(d), .we(we), .exec(exec), .busy(busy), .err(err), .word_cnt(word_cnt)
`ifdef PROG_LOADER_CSUM_EN
    , .csum_bad(csum_bad)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] base);
    load_start = 1'b1;
    base_addr  = base;
    tick();
    load_start = 1'b0;
  endtask

  // Checksum builds need the trailing sum word; default build sends nothing.
  task automatic finish_csum(input logic [DATA_W-1:0] sum);
`ifdef PROG_LOADER_CSUM_EN
    in_valid = 1'b1;
    in_data  = sum;
    in_last  = 1'b0;
    tick();
    in_valid = 1'b0;
`else
    if (sum == '1) tick();
`endif
  endtask

  task automatic test_reset;
    rst = 1'b0; load_start = 0; base_addr = '0; in_valid = 0; in_data = '0; in_last = 0;
    tick(); tick();
    total++;
    if ({a, d, we, exec, in_ready, busy, err, word_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got a=%h d=%h we=%b exec=%b rdy=%b busy=%b err=%b cnt=%0d want all 0",
               a, d, we, exec, in_ready, busy, err, word_cnt);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [DATA_W-1:0] w [6];
    logic [DATA_W-1:0] sum;
    w[0] = 32'h9017_0000; w[1] = 32'h36F7_000D; w[2] = 32'h3C01_1000;
    w[3] = 32'h3421_0010; w[4] = 32'hAC22_0000; w[5] = 32'h8C23_0004;
    sum = '0;
    start_load(9'h000);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_start: got rdy=%b busy=%b want 1 1", in_ready, busy);
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = w[i]; in_last = (i == 5);
      sum += w[i];
      tick();
      total++;
      if (we !== 1'b1 || a !== 9'(i) || d !== w[i]) begin
        bad++; $display("FAIL basic_write[%0d]: got we=%b a=%h d=%h want 1 %h %h", i, we, a, d, 9'(i), w[i]);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_ready_drop: got %b want 0", in_ready);
    end
    finish_csum(sum);
    for (int j = 0; j < SETTLE; j++) begin
      tick();
      total++;
      if (exec !== 1'b0 || we !== 1'b0) begin
        bad++; $display("FAIL basic_settle[%0d]: got exec=%b we=%b want 0 0", j, exec, we);
      end
    end
    tick();
    total++;
    if (exec !== 1'b1 || busy !== 1'b0 || word_cnt !== 10'd6 || err !== 1'b0) begin
      bad++; $display("FAIL basic_exec: got exec=%b busy=%b cnt=%0d err=%b want 1 0 6 0", exec, busy, word_cnt, err);
    end
  endtask

  task automatic test_wrap;
    logic [ADDR_W-1:0] exp_a [4];
    logic [DATA_W-1:0] sum;
    exp_a[0] = 9'h1FE; exp_a[1] = 9'h1FF; exp_a[2] = 9'h000; exp_a[3] = 9'h001;
    sum = '0;
    start_load(9'h1FE);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'hA000_0000 + 32'(i); in_last = (i == 3);
      sum += in_data;
      tick();
      total++;
      if (we !== 1'b1 || a !== exp_a[i] || d !== 32'hA000_0000 + 32'(i)) begin
        bad++; $display("FAIL wrap_write[%0d]: got we=%b a=%h d=%h want 1 %h", i, we, a, d, exp_a[i]);
      end
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      total++;
      if (we !== 1'b0) begin
        bad++; $display("FAIL wrap_gap[%0d]: got we=%b want 0", i, we);
      end
    end
    finish_csum(sum);
    for (int n = 0; n < 20 && exec !== 1'b1; n++) tick();
    total++;
    if (exec !== 1'b1 || word_cnt !== 10'd4 || err !== 1'b0) begin
      bad++; $display("FAIL wrap_exec: got exec=%b cnt=%0d err=%b want 1 4 0", exec, word_cnt, err);
    end
  endtask

  task automatic test_reload;
    logic [DATA_W-1:0] sum;
    sum = '0;
    start_load(9'h040);
    total++;
    if (exec !== 1'b0 || busy !== 1'b1 || word_cnt !== 10'd0) begin
      bad++; $display("FAIL reload_start: got exec=%b busy=%b cnt=%0d want 0 1 0", exec, busy, word_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h5555_0000 + 32'(i); in_last = (i == 1);
      sum += in_data;
      tick();
      total++;
      if (exec !== 1'b0 || we !== 1'b1 || a !== 9'h040 + 9'(i)) begin
        bad++; $display("FAIL reload_write[%0d]: got exec=%b we=%b a=%h want 0 1 %h", i, exec, we, a, 9'h040 + 9'(i));
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    finish_csum(sum);
    for (int j = 0; j < SETTLE; j++) begin
      tick();
      total++;
      if (exec !== 1'b0) begin
        bad++; $display("FAIL reload_settle[%0d]: got exec=%b want 0", j, exec);
      end
    end
    tick();
    total++;
    if (exec !== 1'b1 || word_cnt !== 10'd2) begin
      bad++; $display("FAIL reload_exec: got exec=%b cnt=%0d want 1 2", exec, word_cnt);
    end
  endtask

  task automatic test_overflow;
    start_load(9'h010);
    for (int i = 0; i < TB_DEPTH; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i); in_last = 1'b0;
      tick();
      total++;
      if (we !== 1'b1 || a !== 9'h010 + 9'(i)) begin
        bad++; $display("FAIL ovf_write[%0d]: got we=%b a=%h want 1 %h", i, we, a, 9'h010 + 9'(i));
      end
    end
    in_data = 32'hDEAD;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL ovf_ready: got %b want 0", in_ready);
    end
    tick();
    total++;
    if (we !== 1'b0 || err !== 1'b1 || word_cnt !== 10'(TB_DEPTH) || busy !== 1'b0) begin
      bad++; $display("FAIL ovf_err: got we=%b err=%b cnt=%0d busy=%b want 0 1 %0d 0", we, err, word_cnt, busy, TB_DEPTH);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      total++;
      if (exec !== 1'b0 || err !== 1'b1 || we !== 1'b0) begin
        bad++; $display("FAIL ovf_hold[%0d]: got exec=%b err=%b we=%b want 0 1 0", j, exec, err, we);
      end
    end
    start_load(9'h000);
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL ovf_clear: got err=%b busy=%b want 0 1", err, busy);
    end
    in_valid = 1'b1; in_data = 32'h77; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    finish_csum(32'h77);
    for (int n = 0; n < 20 && exec !== 1'b1; n++) tick();
    total++;
    if (exec !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL ovf_recover: got exec=%b err=%b want 1 0", exec, err);
    end
  endtask

  task automatic test_reset_midload;
    start_load(9'h020);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hC0 + 32'(i); in_last = 1'b0;
      tick();
    end
    rst = 1'b0; in_data = 32'hC3;
    tick();
    total++;
    if ({a, d, we, exec, in_ready, busy, err, word_cnt} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got a=%h d=%h we=%b exec=%b rdy=%b busy=%b err=%b cnt=%0d want all 0",
               a, d, we, exec, in_ready, busy, err, word_cnt);
    end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    total++;
    if (we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset_idle: got we=%b rdy=%b busy=%b want 0 0 0", we, in_ready, busy);
    end
    start_load(9'h030);
    in_valid = 1'b1; in_data = 32'h11; in_last = 1'b0;
    tick();
    in_data = 32'h22; in_last = 1'b1;
    tick();
    total++;
    if (we !== 1'b1 || a !== 9'h031 || d !== 32'h22) begin
      bad++; $display("FAIL midreset_reload: got we=%b a=%h d=%h want 1 031 22", we, a, d);
    end
    in_valid = 1'b0; in_last = 1'b0;
    finish_csum(32'h33);
    for (int n = 0; n < 20 && exec !== 1'b1; n++) tick();
    total++;
    if (exec !== 1'b1 || word_cnt !== 10'd2) begin
      bad++; $display("FAIL midreset_exec: got exec=%b cnt=%0d want 1 2", exec, word_cnt);
    end
  endtask

`ifdef PROG_LOADER_CSUM_EN
  task automatic test_csum;
    for (int pass = 0; pass < 2; pass++) begin
      start_load(9'h000);
      for (int i = 1; i <= 3; i++) begin
        in_valid = 1'b1; in_data = 32'(i); in_last = (i == 3);
        tick();
      end
      in_last = 1'b0; in_data = (pass == 0) ? 32'd6 : 32'd7;
      tick();
      in_valid = 1'b0;
      total++;
      if (we !== 1'b0) begin
        bad++; $display("FAIL csum_nowrite[%0d]: got we=%b want 0", pass, we);
      end
      for (int n = 0; n < 10; n++) tick();
      total++;
      if (pass == 0 && (exec !== 1'b1 || csum_bad !== 1'b0 || err !== 1'b0)) begin
        bad++; $display("FAIL csum_good: got exec=%b csum_bad=%b err=%b want 1 0 0", exec, csum_bad, err);
      end else if (pass == 1 && (exec !== 1'b0 || csum_bad !== 1'b1 || err !== 1'b1)) begin
        bad++; $display("FAIL csum_bad: got exec=%b csum_bad=%b err=%b want 0 1 1", exec, csum_bad, err);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_reload();
    test_overflow();
    test_reset_midload();
`ifdef PROG_LOADER_CSUM_EN
    test_csum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
